// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 key + joystick merge into per-player controls with rotation, coin pulses and autofire
// Ports: clk_sys/reset (async, active high); ps2_key hps_io key word; joystick_0/1 MiSTer words;
// rotate selects horizontal remap; autofire per-player enable; up/down/left/right/fire/coin per player; start = {start2, start1}.
module arcade_input_mapper #(
  parameter int          NPLAYERS      = 2,
  parameter logic [15:0] COIN_PULSE    = 16'd50000,
  parameter logic [19:0] AF_HALF       = 20'd400000,
  parameter bit          COIN_ON_START = 1'b1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [64:0]         ps2_key,
  input  logic [15:0]         joystick_0,
  input  logic [15:0]         joystick_1,
  input  logic                rotate,
  input  logic [NPLAYERS-1:0] autofire,
  output logic [NPLAYERS-1:0] up,
  output logic [NPLAYERS-1:0] down,
  output logic [NPLAYERS-1:0] left,
  output logic [NPLAYERS-1:0] right,
  output logic [NPLAYERS-1:0] fire,
  output logic [1:0]          start,
  output logic [NPLAYERS-1:0] coin
);
  logic                old_state_q, armed_q;
  logic [14:0]         key_q, key_d, hit;
  logic                pressed, extended, ev;
  logic [8:0]          code;
  logic [7:0]          jp0, jp1;
  logic [1:0]          m_up, m_down, m_left, m_right, m_fire, start_d, req;
  logic [1:0]          r_up, r_down, r_left, r_right;
  logic [NPLAYERS-1:0] up_q, down_q, left_q, right_q;
  logic [1:0]          start_q;
  logic                unused;
  assign unused = ^{joystick_0[15:8], joystick_1[15:8], jp0[6:5], jp1[6:5]};
  // key_q bit order: 0-3 p0 up/down/left/right (extended bit ignored), 4-5 p0 fire, 6-7 start1/2,
  // 8 p0 coin, 9-12 p1 up/down/left/right, 13 p1 fire, 14 p1 coin
  always_comb begin
    pressed  = ps2_key[15:8] != 8'hF0;
    extended = pressed ? ps2_key[15:8] == 8'hE0 : ps2_key[23:16] == 8'hE0;
    code     = ps2_key[63:24] != '0 ? 9'd0 : {extended, ps2_key[7:0]};
    ev       = armed_q && ps2_key[64] != old_state_q;
    hit      = {code == 9'h036, code == 9'h01C, code == 9'h034, code == 9'h023, code == 9'h02B,
                code == 9'h02D, code == 9'h02E, code == 9'h006, code == 9'h005, code == 9'h014,
                code == 9'h029, code[7:0] == 8'h74, code[7:0] == 8'h6B, code[7:0] == 8'h72,
                code[7:0] == 8'h75};
    key_d    = ev ? (key_q & ~hit) | (hit & {15{pressed}}) : key_q;
    jp0      = NPLAYERS == 1 ? joystick_0[7:0] | joystick_1[7:0] : joystick_0[7:0];
    jp1      = joystick_1[7:0];
    m_up     = {key_q[9]  | jp1[3], key_q[0] | jp0[3]};
    m_down   = {key_q[10] | jp1[2], key_q[1] | jp0[2]};
    m_left   = {key_q[11] | jp1[1], key_q[2] | jp0[1]};
    m_right  = {key_q[12] | jp1[0], key_q[3] | jp0[0]};
    m_fire   = {key_q[13] | jp1[4], key_q[4] | key_q[5] | jp0[4]};
    r_up     = rotate ? m_left  : m_up;
    r_down   = rotate ? m_right : m_down;
    r_left   = rotate ? m_down  : m_left;
    r_right  = rotate ? m_up    : m_right;
    start_d  = {key_q[7] | joystick_0[6] | joystick_1[6], key_q[6] | joystick_0[5] | joystick_1[5]};
    req      = {key_q[14] | jp1[7], key_q[8] | jp0[7]} | (COIN_ON_START ? start_d : 2'b00);
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      old_state_q <= 1'b0;
      armed_q     <= 1'b0;
      key_q       <= '0;
      up_q        <= '0;
      down_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      start_q     <= '0;
    end else begin
      old_state_q <= ps2_key[64];
      armed_q     <= 1'b1;
      key_q       <= key_d;
      up_q        <= r_up[NPLAYERS-1:0];
      down_q      <= r_down[NPLAYERS-1:0];
      left_q      <= r_left[NPLAYERS-1:0];
      right_q     <= r_right[NPLAYERS-1:0];
      start_q     <= start_d;
    end
  assign up    = up_q;
  assign down  = down_q;
  assign left  = left_q;
  assign right = right_q;
  assign start = start_q;
  for (genvar p = 0; p < NPLAYERS; p++) begin : g_pl
    logic [15:0] coin_cnt_q, coin_cnt_d;
    logic [19:0] af_cnt_q, af_cnt_d;
    logic        req_q, coin_q, coin_d, phase_q, phase_d, fire_q, fire_d, af_on, wrap;
    // a new pulse is only accepted once the previous one has fully drained
    always_comb begin
      coin_cnt_d = coin_cnt_q != '0 ? coin_cnt_q - 16'd1 : req[p] && !req_q ? COIN_PULSE : 16'd0;
      coin_d     = coin_cnt_d != '0;
      af_on      = autofire[p] && m_fire[p];
      wrap       = af_cnt_q == AF_HALF - 20'd1;
      af_cnt_d   = af_on && !wrap ? af_cnt_q + 20'd1 : 20'd0;
      phase_d    = af_on && (phase_q ^ wrap);
      fire_d     = autofire[p] ? af_on && !phase_q : m_fire[p];
    end
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
        coin_cnt_q <= '0;
        af_cnt_q   <= '0;
        req_q      <= 1'b0;
        coin_q     <= 1'b0;
        phase_q    <= 1'b0;
        fire_q     <= 1'b0;
      end else begin
        coin_cnt_q <= coin_cnt_d;
        af_cnt_q   <= af_cnt_d;
        req_q      <= req[p];
        coin_q     <= coin_d;
        phase_q    <= phase_d;
        fire_q     <= fire_d;
      end
    assign coin[p] = coin_q;
    assign fire[p] = fire_q;
  end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: randomized check of two mapper instances (2 players and 1 player) against a behavioural model
module tb_arcade_input_mapper;
  localparam int CPI = 4;
  localparam int AHI = 3;
  logic        clk = 1'b0, rst = 1'b1;
  logic [64:0] ps2 = '0;
  logic [15:0] j0 = '0, j1 = '0;
  logic        rot = 1'b0;
  logic [1:0]  af = '0;
  logic [1:0]  up, down, left, right, fire, start, coin;
  logic        up1, down1, left1, right1, fire1, coin1;
  logic [1:0]  start1;
  int          n_checks = 0, n_errors = 0;
  logic [7:0]  codes [16] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06,
                              8'h2E, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h36, 8'h33};
  bit   [511:0] keys;
  bit           armed, old;
  int           cyc;
  int           coin_end [2][2];
  int           af_start [2][2];
  bit           req_prev [2][2];
  bit           af_prev [2][2];
  logic [1:0]   e_up [2], e_down [2], e_left [2], e_right [2], e_fire [2], e_coin [2];
  logic [1:0]   e_start;
  always #5 clk = ~clk;
  arcade_input_mapper #(.NPLAYERS(2), .COIN_PULSE(16'(CPI)), .AF_HALF(20'(AHI)), .COIN_ON_START(1'b1)) dut (
    .clk_sys(clk), .reset(rst), .ps2_key(ps2), .joystick_0(j0), .joystick_1(j1), .rotate(rot),
    .autofire(af), .up(up), .down(down), .left(left), .right(right), .fire(fire), .start(start), .coin(coin));
  arcade_input_mapper #(.NPLAYERS(1), .COIN_PULSE(16'(CPI)), .AF_HALF(20'(AHI)), .COIN_ON_START(1'b1)) dut1 (
    .clk_sys(clk), .reset(rst), .ps2_key(ps2), .joystick_0(j0), .joystick_1(j1), .rotate(rot),
    .autofire(af[0]), .up(up1), .down(down1), .left(left1), .right(right1), .fire(fire1), .start(start1), .coin(coin1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    keys = '0;
    armed = 1'b0;
    old = 1'b0;
    cyc = 0;
    e_start = '0;
    for (int i = 0; i < 2; i++) begin
      e_up[i] = '0; e_down[i] = '0; e_left[i] = '0; e_right[i] = '0; e_fire[i] = '0; e_coin[i] = '0;
      for (int p = 0; p < 2; p++) begin
        coin_end[i][p] = -100;
        af_start[i][p] = 0;
        req_prev[i][p] = 1'b0;
        af_prev[i][p]  = 1'b0;
      end
    end
  endtask
  // outputs after the coming edge follow the key state held before it; the key event lands afterwards
  task automatic model_step();
    logic [15:0] jp [2];
    logic [3:0]  d;
    logic [1:0]  st;
    logic        f, on, req, pr;
    logic [8:0]  kc;
    st = {keys[9'h006] | j0[6] | j1[6], keys[9'h005] | j0[5] | j1[5]};
    e_start = st;
    for (int i = 0; i < 2; i++) begin
      jp[0] = i == 0 ? j0 : j0 | j1;
      jp[1] = j1;
      for (int p = 0; p < 2 - i; p++) begin
        d = jp[p][3:0] | (p == 0 ? {keys[9'h075], keys[9'h072], keys[9'h06B], keys[9'h074]}
                                 : {keys[9'h02D], keys[9'h02B], keys[9'h023], keys[9'h034]});
        if (rot) d = {d[1], d[0], d[2], d[3]};
        {e_up[i][p], e_down[i][p], e_left[i][p], e_right[i][p]} = d;
        f  = jp[p][4] | (p == 0 ? keys[9'h029] | keys[9'h014] : keys[9'h01C]);
        on = af[p] & f;
        if (on && !af_prev[i][p]) af_start[i][p] = cyc;
        af_prev[i][p] = on;
        e_fire[i][p] = af[p] ? on && ((cyc - af_start[i][p]) / AHI) % 2 == 0 : f;
        req = jp[p][7] | (p == 0 ? keys[9'h02E] : keys[9'h036]) | st[p];
        if (req && !req_prev[i][p] && cyc > coin_end[i][p]) coin_end[i][p] = cyc + CPI;
        req_prev[i][p] = req;
        e_coin[i][p] = cyc < coin_end[i][p];
      end
    end
    if (!armed) begin
      armed = 1'b1;
      old = ps2[64];
    end else if (ps2[64] != old) begin
      old = ps2[64];
      if (ps2[63:24] == '0) begin
        pr = ps2[15:8] != 8'hF0;
        kc = {pr ? ps2[15:8] == 8'hE0 : ps2[23:16] == 8'hE0, ps2[7:0]};
        if (kc[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) kc[8] = 1'b0;
        keys[kc] = pr;
      end
    end
    cyc++;
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("up", up, e_up[0]);
    check("down", down, e_down[0]);
    check("left", left, e_left[0]);
    check("right", right, e_right[0]);
    check("fire", fire, e_fire[0]);
    check("start", start, e_start);
    check("coin", coin, e_coin[0]);
    check("np1_dirs", {up1, down1, left1, right1}, {e_up[1][0], e_down[1][0], e_left[1][0], e_right[1][0]});
    check("np1_fire", fire1, e_fire[1][0]);
    check("np1_start", start1, e_start);
    check("np1_coin", coin1, e_coin[1][0]);
  endtask
  initial begin
    int hi, hold;
    logic [11:0] pat;
    logic [7:0]  lo;
    bit          ex, pr;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {up, down, left, right, fire, start, coin, up1, down1, left1, right1, fire1, start1, coin1}, 0);
    ps2 = {1'b1, 40'h0, 24'h00E075};
    rst = 1'b0;
    step();
    check("arm_edge_up", up[0], 0);
    ps2[64] = 1'b0;
    step();
    check("key_up_edge1", up[0], 0);
    step();
    check("key_up_edge2", up[0], 1);
    ps2 = {1'b1, 40'h0, 24'hE0F075};
    step();
    step();
    check("key_up_release", up[0], 0);
    j0 = 16'h0008;
    rot = 1'b1;
    step();
    check("rot_right", right[0], 1);
    check("rot_up", up[0], 0);
    rot = 1'b0;
    step();
    check("norot_up", up[0], 1);
    j0 = '0;
    step();
    hi = 0;
    for (int k = 0; k < 14; k++) begin
      j1 = (k < 10 && k != 1) ? 16'h0080 : 16'h0000;
      step();
      hi += int'(coin[1]);
    end
    check("coin_width", hi, CPI);
    af[0] = 1'b1;
    j0 = 16'h0010;
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      pat = {pat[10:0], fire[0]};
    end
    check("af_pattern", pat, 12'b111000111000);
    j0 = '0;
    step();
    check("af_release", fire[0], 0);
    af = '0;
    j1 = 16'h0010;
    step();
    check("np1_joy1_fire", fire1, 1);
    j1 = '0;
    ps2 = {~ps2[64], 40'h0, 24'h00001C};
    step();
    step();
    check("np1_key_ignored", fire1, 0);
    check("p1_key_fire", fire[1], 1);
    ps2 = {~ps2[64], 40'h0, 24'h00F01C};
    step();
    step();
    ps2 = {~ps2[64], 40'h1, 24'h000075};
    step();
    step();
    check("junk_ignored", up[0], 0);
    hold = 0;
    for (int t = 0; t < 2500; t++) begin
      if (hold == 0) begin
        j0 = 16'($urandom) & 16'($urandom) & 16'($urandom);
        j1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
        rot = $urandom_range(0, 3) == 0;
        af = 2'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) begin
        lo = codes[$urandom_range(0, 15)];
        ex = $urandom_range(0, 3) == 0;
        pr = 1'($urandom);
        ps2[15:0]  = pr ? {ex ? 8'hE0 : 8'h00, lo} : {8'hF0, lo};
        ps2[23:16] = !pr && ex ? 8'hE0 : 8'h00;
        ps2[63:24] = $urandom_range(0, 15) == 0 ? {8'h0, $urandom} | 40'h1 : 40'h0;
        ps2[64]    = ~ps2[64];
      end
      step();
    end
    j0 = '0;
    af = '0;
    j1 = 16'h0080;
    step();
    step();
    j1 = '0;
    #3;
    rst = 1'b1;
    #1;
    check("reset_cuts_coin", {coin, coin1}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 300; t++) begin
      j0 = 16'($urandom) & 16'($urandom) & 16'($urandom);
      j1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 2) == 0) ps2 = {~ps2[64], 40'h0, 8'h00, $urandom_range(0, 1) ? 8'hF0 : 8'h00, codes[$urandom_range(0, 15)]};
      step();
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for the arcade cores. It decodes PS/2 key events and merges them with MiSTer joystick words into per-player, active-high control lines for the game core, with optional screen-rotation remapping. It also generates fixed-width coin pulses and a per-player autofire gate. It sits between `hps_io` and the game core, clocked by `clk_sys`, and replaces the ad-hoc key/joystick glue in each core's top level.

## Interface
Parameters:
- `NPLAYERS`, default 2: number of player channels (1 or 2). When 1, `joystick_0 | joystick_1` drives player 0.
- `COIN_PULSE`, default 16'd50000: coin pulse width in `clk_sys` cycles (≥1, 16-bit).
- `AF_HALF`, default 20'd400000: autofire half-period in cycles (≥1, 20-bit).
- `COIN_ON_START`, default 1: a start request also raises that player's coin request.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_key` in 65: `hps_io` key word. Bit 64 toggles per event; [15:8]=F0 means release; E0 means extended.
- `joystick_0`, `joystick_1` in 16 each: bit 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
- `rotate` in 1: 1 = horizontal-orientation remap.
- `autofire` in NPLAYERS: per-player autofire enable.
- `up`, `down`, `left`, `right`, `fire` out NPLAYERS each: merged controls, bit p = player p.
- `start` out 2: start1 and start2.
- `coin` out NPLAYERS: coin pulses.

## Operation
- Event detect: `old_state` register plus `armed` flag. Both are cleared on reset. The first edge after reset sets `armed` and captures bit 64 without decoding. After that, an event is any cycle where ps2_key[64] != `old_state`.
- Decode:
  - pressed = (ps2_key[15:8] != F0).
  - extended = pressed ? ps2_key[15:8]==E0 : ps2_key[23:16]==E0.
  - code = {extended, ps2_key[7:0]}, forced to 0 if ps2_key[63:24] != 0 (PrtScr/Pause ignored).
  - On an event, the matching key register takes `pressed`.
- Key map for player 0:
  - up X75, down X72, left X6B, right X74 (X = don't-care extended bit).
  - fire 029 or 014.
  - start1 005, start2 006.
  - coin 02E.
- Key map for player 1 (NPLAYERS=2 only): up 02D, down 02B, left 023, right 034, fire 01C, coin 036.
- Merge per player: key OR joystick bit. `start` = OR of start keys and bit 5/6 of all joysticks.
- Rotate (after merge, when `rotate`=1): up←left, down←right, left←down, right←up.
- Coin generation, per player:
  - Request = coin key | joy bit 7 | (COIN_ON_START & matching start).
  - A request rising edge while the counter is 0 loads COIN_PULSE. The output is high while the counter is nonzero, and the counter decrements each cycle.
  - Edges during an active pulse are ignored; there is no queueing.
- Autofire, per player:
  - When `autofire[p]`=1 and merged fire is held, the output fire is high for AF_HALF cycles, then low for AF_HALF cycles, repeating, starting high on the press.
  - Releasing fire clears the phase counter and forces the output low.
  - When `autofire[p]`=0, fire passes through.

## Timing
- All outputs are registered, and all reset to 0. Key registers, counters, `old_state` and `armed` also reset to 0.
- Key path latency is 2 edges: the key register updates on the event edge, and the output updates on the next edge.
- Joystick path and `rotate` latency is 1 edge.
- The coin output rises 2 edges after a key request edge, or 1 edge after a joystick request edge. It stays high for exactly COIN_PULSE cycles.
- Simultaneous key release and joystick press: the output stays 1 (OR).
- Counter boundaries: the coin counter saturates at 0. The autofire counter wraps at AF_HALF−1 and toggles phase.
- Reset mid-pulse: the pulse is cut immediately, because reset is asynchronous.

## Test plan
- Reset, then ps2_key = {1'b1, 40'h0, 16'hE075}: no change on the first post-reset edge (the arming edge). Toggling bit 64 with the same code then drives up[0]=1 two edges later. Sending {…,16'hF075}-style release E0 F0 75 returns up[0] to 0.
- joystick_0 = 16'h0008 with rotate=1: right[0]=1 and up[0]=0 after 1 edge. With rotate=0: up[0]=1.
- COIN_PULSE=4: joystick_1 bit 7 rises and holds 10 cycles, then falls. Expect coin[1] high for exactly 4 cycles and no second pulse. A second edge at cycle 2 is also ignored.
- AF_HALF=3 with autofire[0]=1 and joystick_0 bit 4 held for 12 cycles: fire[0] pattern is 111000111000. On release, fire[0]=0 on the next edge.
- NPLAYERS=1: joystick_1 = 16'h0010 gives fire[0]=1. Key 01C is ignored.
- Key code with ps2_key[63:24]=nonzero: no key register changes.
